// File: rtl/nn_seq_pkg.sv
// Shared state encodings, activation selects and width helpers for nn_layer_sequencer.
package nn_seq_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_ISSUE = 3'd1;
    localparam logic [2:0] ST_WAIT  = 3'd2;
    localparam logic [2:0] ST_WRITE = 3'd3;
    localparam logic [2:0] ST_FIN   = 3'd4;

    localparam logic [1:0] ACT_SIGMOID = 2'd1;
    localparam logic [1:0] ACT_SOFTMAX = 2'd2;

    // Address width for n locations; never narrower than one bit.
    function automatic int width_of(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max_of(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/nn_seq_watchdog.sv
// Loadable down-counter with expiry flag used to bound the per-neuron wait.
// Only present when NN_SEQ_WATCHDOG_EN is defined.
`ifdef NN_SEQ_WATCHDOG_EN
module nn_seq_watchdog
    import nn_seq_pkg::*;
#(
    parameter int CW = 12
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load_i,
    input  logic          en_i,
    input  logic [CW-1:0] load_val_i,
    output logic          expired_o
);

    logic [CW-1:0] cnt_d;
    logic [CW-1:0] cnt_q;

    // Load on neuron issue, then count down while waiting; saturate at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (en_i && (cnt_q != {CW{1'b0}})) begin
            cnt_d = cnt_q - CW'(1'b1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= {CW{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired_o = (cnt_q == {CW{1'b0}});

endmodule
`endif

// File: rtl/nn_layer_sequencer.sv
// Runs a two-layer network one neuron at a time through a shared neuron unit.
// Optional per-neuron wait watchdog: define NN_SEQ_WATCHDOG_EN.
module nn_layer_sequencer
    import nn_seq_pkg::*;
#(
    parameter  int L0      = 100,
    parameter  int L1      = 15,
    parameter  int L2      = 10,
    parameter  int TIMEOUT = 4096,
    localparam int WA_W    = width_of(L0 * L1 + L1 * L2),
    localparam int BA_W    = width_of(L1 + L2),
    localparam int IX_W    = width_of(max_of(L1, L2)),
    localparam int LN_W    = width_of(max_of(L0, L1) + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    output logic            busy,
    output logic            done,
    output logic            error,
    output logic            nrn_start,
    input  logic            nrn_done,
    output logic            nrn_layer,
    output logic [IX_W-1:0] nrn_index,
    output logic [WA_W-1:0] w_base,
    output logic [BA_W-1:0] b_addr,
    output logic [LN_W-1:0] in_len,
    output logic [1:0]      act_sel,
    output logic            res_we,
    output logic [BA_W-1:0] res_addr
);

    if (TIMEOUT < 1) begin : g_timeout_chk
        $error("nn_layer_sequencer: TIMEOUT must be at least 1");
    end

    logic [2:0]      state_d, state_q;
    logic            layer_d, layer_q;
    logic [IX_W-1:0] idx_d, idx_q, last_idx_s;
    logic [WA_W-1:0] w_base_d, w_base_q;
    logic [BA_W-1:0] b_addr_d, b_addr_q;
    logic [LN_W-1:0] in_len_d, in_len_q;
    logic [1:0]      act_sel_d, act_sel_q;
    logic            nrn_start_q, res_we_q, done_q, busy_q;
    logic            wd_expired_s;

    // Next-state and neuron-cursor logic.
    always_comb begin
        state_d    = state_q;
        layer_d    = layer_q;
        idx_d      = idx_q;
        last_idx_s = layer_q ? IX_W'(L2 - 1) : IX_W'(L1 - 1);
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    layer_d = 1'b0;
                    idx_d   = {IX_W{1'b0}};
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: state_d = ST_WAIT;
            ST_WAIT: begin
                if (nrn_done) begin
                    state_d = ST_WRITE;
                end else if (wd_expired_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WAIT;
                end
            end
            ST_WRITE: begin
                if (idx_q < last_idx_s) begin
                    idx_d   = idx_q + IX_W'(1'b1);
                    state_d = ST_ISSUE;
                end else if (!layer_q) begin
                    layer_d = 1'b1;
                    idx_d   = {IX_W{1'b0}};
                    state_d = ST_ISSUE;
                end else begin
                    state_d = ST_FIN;
                end
            end
            ST_FIN:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Neuron descriptor is captured on entry to ISSUE and held until the next neuron.
    always_comb begin
        w_base_d  = w_base_q;
        b_addr_d  = b_addr_q;
        in_len_d  = in_len_q;
        act_sel_d = act_sel_q;
        if ((state_d == ST_ISSUE) && (state_q != ST_ISSUE)) begin
            if (layer_d) begin
                w_base_d  = WA_W'(L0 * L1 + L1 * int'(idx_d));
                b_addr_d  = BA_W'(L1 + int'(idx_d));
                in_len_d  = LN_W'(L1);
                act_sel_d = ACT_SOFTMAX;
            end else begin
                w_base_d  = WA_W'(L0 * int'(idx_d));
                b_addr_d  = BA_W'(int'(idx_d));
                in_len_d  = LN_W'(L0);
                act_sel_d = ACT_SIGMOID;
            end
        end else begin
            w_base_d  = w_base_q;
            b_addr_d  = b_addr_q;
            in_len_d  = in_len_q;
            act_sel_d = act_sel_q;
        end
    end

    // State, cursor, descriptor and strobe registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            layer_q     <= 1'b0;
            idx_q       <= {IX_W{1'b0}};
            w_base_q    <= {WA_W{1'b0}};
            b_addr_q    <= {BA_W{1'b0}};
            in_len_q    <= {LN_W{1'b0}};
            act_sel_q   <= 2'd0;
            nrn_start_q <= 1'b0;
            res_we_q    <= 1'b0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            layer_q     <= layer_d;
            idx_q       <= idx_d;
            w_base_q    <= w_base_d;
            b_addr_q    <= b_addr_d;
            in_len_q    <= in_len_d;
            act_sel_q   <= act_sel_d;
            nrn_start_q <= (state_d == ST_ISSUE);
            res_we_q    <= (state_d == ST_WRITE);
            done_q      <= (state_d == ST_FIN);
            busy_q      <= (state_d != ST_IDLE);
        end
    end

`ifdef NN_SEQ_WATCHDOG_EN
    localparam int WD_W = width_of(TIMEOUT);

    logic err_d, err_q;

    nn_seq_watchdog #(
        .CW(WD_W)
    ) u_watchdog (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (state_q == ST_ISSUE),
        .en_i       (state_q == ST_WAIT),
        .load_val_i (WD_W'(TIMEOUT - 1)),
        .expired_o  (wd_expired_s)
    );

    // Sticky timeout flag, cleared only by an accepted start.
    always_comb begin
        if ((state_q == ST_IDLE) && start) begin
            err_d = 1'b0;
        end else if ((state_q == ST_WAIT) && !nrn_done && wd_expired_s) begin
            err_d = 1'b1;
        end else begin
            err_d = err_q;
        end
    end

    // Error flag register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign error = err_q;
`else
    assign wd_expired_s = 1'b0;
    assign error        = 1'b0;
`endif

    assign busy      = busy_q;
    assign done      = done_q;
    assign nrn_start = nrn_start_q;
    assign nrn_layer = layer_q;
    assign nrn_index = idx_q;
    assign w_base    = w_base_q;
    assign b_addr    = b_addr_q;
    assign in_len    = in_len_q;
    assign act_sel   = act_sel_q;
    assign res_we    = res_we_q;
    assign res_addr  = b_addr_q;

endmodule

// File: doc/nn_layer_sequencer.md
# nn_layer_sequencer

Sequencer that runs the two-layer MNIST network (L0 inputs → L1 hidden → L2 outputs) through one shared single-neuron compute unit, one neuron at a time. For each neuron it issues a start pulse to the shared unit, presents the weight-row base address, bias address, vector length and activation select, then waits for completion. It then commands a write of the neuron result into the hidden buffer (layer 1) or the output buffer (layer 2). It sits between the testbench or host `start`/`done` handshake and the neuron datapath plus its weight, bias and activation memories.

## Interface
- `L0`, 100: input vector length.
- `L1`, 15: hidden neurons, sigmoid.
- `L2`, 10: output neurons, softmax applied downstream.
- `TIMEOUT`, 4096: maximum wait cycles per neuron; used only with the watchdog configuration macro.
- Derived: `WA_W = $clog2(L0*L1 + L1*L2)`, `BA_W = $clog2(L1+L2)`, `IX_W = $clog2(max(L1,L2))`, `LN_W = $clog2(max(L0,L1)+1)`.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: run request; sampled only in IDLE.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after the last output neuron is written.
- `error` out 1: sticky watchdog flag.
- `nrn_start` out 1: one-cycle pulse to the shared neuron unit.
- `nrn_done` in 1: neuron result valid; sampled only in WAIT.
- `nrn_layer` out 1: 0 = layer 1, 1 = layer 2.
- `nrn_index` out IX_W: neuron index within the current layer.
- `w_base` out WA_W: flattened weight-row base address.
- `b_addr` out BA_W: flattened bias address.
- `in_len` out LN_W: dot-product length.
- `act_sel` out 2: 1 = sigmoid (layer 1), 2 = identity/softmax-pending (layer 2).
- `res_we` out 1: result write strobe.
- `res_addr` out BA_W: result address; hidden buffer at 0..L1-1, output buffer at L1..L1+L2-1.

## Operation
- States: IDLE → ISSUE → WAIT → WRITE → (ISSUE | FIN) → IDLE.
- IDLE:
  - `start`=1 → clear `error`, set layer=0 and index=0, go to ISSUE.
  - `start` in any other state is ignored.
- ISSUE: `nrn_start`=1 for exactly one cycle, then go to WAIT.
- WAIT: hold until `nrn_done`=1, then go to WRITE. A `nrn_done` seen in any other state is ignored.
- WRITE:
  - `res_we`=1 for one cycle; `res_addr` equals `b_addr`.
  - Then advance: if index < size-1, index+1 and go to ISSUE.
  - Else if layer 0: set layer=1, index=0, go to ISSUE.
  - Else go to FIN.
- FIN: `done`=1 for one cycle, then go to IDLE.
- Address rules (all unsigned, no wrap):
  - Layer 1: `w_base` = idx·L0, `b_addr` = idx, `in_len` = L0, `act_sel` = 1.
  - Layer 2: `w_base` = L0·L1 + idx·L1, `b_addr` = L1 + idx, `in_len` = L1, `act_sel` = 2.
- `nrn_layer`, `nrn_index`, `w_base`, `b_addr`, `in_len` and `act_sel` are registered. They are stable from ISSUE through WRITE of each neuron.
- Reset values: all outputs are 0 and the state is IDLE. Reset asserted mid-run aborts immediately; no `done` pulse follows.

## Timing
- Per-neuron cost: 1 (ISSUE) + k (WAIT, k ≥ 1 cycles until `nrn_done`) + 1 (WRITE).
- `nrn_done` is earliest observable one cycle after the `nrn_start` pulse.
- Total run latency from the `start` edge to the `done` pulse: 1 + Σ(k_i + 2) over L1+L2 neurons + 1.
- `busy` rises the cycle after `start` is accepted and falls the cycle after `done`.
- A new `start` is accepted in the first IDLE cycle following `done`.

## Configuration
- `NN_SEQ_WATCHDOG_EN` defined:
  - A counter runs in WAIT. If it reaches `TIMEOUT` without `nrn_done`, `error` is set and the FSM returns to IDLE with no `done` pulse.
  - `error` stays high until the next accepted `start` or until reset.
- `NN_SEQ_WATCHDOG_EN` not defined: no counter is built, `error` is tied to 0, and WAIT waits indefinitely.

## Structure
- Package `nn_seq_pkg`:
  - State encoding constants (IDLE, ISSUE, WAIT, WRITE, FIN).
  - `ACT_SIGMOID` = 1 and `ACT_SOFTMAX` = 2.
  - Width helper functions.
- Sub-module `nn_seq_watchdog`: loadable down-counter with expiry flag. It is instantiated only under the macro.

## Test plan
- Bench parameters L0=4, L1=3, L2=2; neuron stub answers `nrn_done` 3 cycles after `nrn_start`.
  - Stimulus: `start`.
  - Response: 5 `nrn_start` pulses; `w_base` sequence 0, 4, 8, 12, 15; `b_addr`/`res_addr` sequence 0, 1, 2, 3, 4.
  - Response: `act_sel` 1, 1, 1, 2, 2; `done` pulse exactly 27 cycles after `start` is sampled.
- Pulse `start` again while `busy`=1 → no restart; the `nrn_index` sequence is unchanged.
- Stub with `nrn_done` pulsed during ISSUE and WRITE as well → spurious pulses ignored; exactly 5 `res_we` strobes.
- Assert `rst_n`=0 during the third WAIT, release, then `start` → all outputs 0 during reset; the fresh run begins at index 0 with `w_base` 0.
- With `NN_SEQ_WATCHDOG_EN` and `TIMEOUT`=8, stub never answers → `error`=1 after 8 WAIT cycles, `busy`=0, no `done`; the next `start` clears `error`.
- Default parameters, stub latency 1 → final neuron shows `w_base`=1635 and `b_addr`=24; `done` arrives 77 cycles after `start`.
